mmio_ctrl: RTL



---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_counter.sv | 24 ++
 rtl/mmio_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: IO register offsets and TX buffer state encoding shared by the mmio block.
// Latency: n/a. Backpressure: n/a.
package mmio_pkg;

  localparam logic [7:0] UART_CTRL = 8'h00;
  localparam logic [7:0] UART_RX   = 8'h04;
  localparam logic [7:0] UART_TX   = 8'h08;
  localparam logic [7:0] CYC_CNT   = 8'h10;
  localparam logic [7:0] INSTR_CNT = 8'h14;
  localparam logic [7:0] CNT_CLR   = 8'h18;
  localparam logic [7:0] BR_CNT    = 8'h1C;
  localparam logic [7:0] BR_OK_CNT = 8'h20;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_t;

endpackage

// File: rtl/mmio_counter.sv
// mmio_counter: free-running event counter with enable and synchronous clear; wraps silently.
// Latency: count reflects an increment one edge later. Backpressure: none.
module mmio_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: IO-space registers (UART rx/tx, perf counters; MMIO_BR_COUNTERS_EN adds branch counters).
// Latency: load data registered, valid one cycle after the request; stores act at the edge.
// Backpressure: stall while a TX store meets a full buffer with tx_ready low; rx pops via rx_ready.
module mmio_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        instr_retire,
  input  logic        br_retire,
  input  logic        br_correct,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] rdata,
  output logic        stall
);

  import mmio_pkg::*;

  tx_state_t   tx_state;
  logic [7:0]  tx_buf;
  logic [7:0]  off;
  logic        is_ld;
  logic        is_st;
  logic        tx_full;
  logic        tx_accept;
  logic        cnt_clr;
  logic [31:0] rdata_nxt;
  logic [31:0] cyc_cnt;
  logic [31:0] instr_cnt;
  logic [31:0] br_cnt;
  logic [31:0] br_ok_cnt;
  logic        unused_bits;

  assign off     = req_addr[7:0];
  assign is_ld   = req_valid && !req_we;
  assign is_st   = req_valid && req_we;
  assign tx_full = (tx_state == TX_FULL);

  // Handshake outputs are masked by rst so reset overrides any same-cycle access.
  assign rx_ready  = !rst && is_ld && (off == UART_RX) && rx_valid;
  assign stall     = !rst && is_st && (off == UART_TX) && tx_full && !tx_ready;
  assign tx_accept = is_st && (off == UART_TX) && !stall;
  assign cnt_clr   = is_st && (off == CNT_CLR);

  assign tx_valid = tx_full;
  assign tx_data  = tx_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_EMPTY;
      tx_buf   <= '0;
    end else begin
      case (tx_state)
        TX_EMPTY: begin
          if (tx_accept) begin
            tx_state <= TX_FULL;
            tx_buf   <= req_wdata[7:0];
          end
        end
        TX_FULL: begin
          // A store can only be accepted here when tx_ready drains the old byte.
          if (tx_accept) begin
            tx_buf <= req_wdata[7:0];
          end else if (tx_ready) begin
            tx_state <= TX_EMPTY;
          end
        end
        default: tx_state <= TX_EMPTY;
      endcase
    end
  end

  mmio_counter #(.WIDTH(32)) u_cyc_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (1'b1),
    .count (cyc_cnt)
  );

  mmio_counter #(.WIDTH(32)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (instr_retire),
    .count (instr_cnt)
  );

`ifdef MMIO_BR_COUNTERS_EN
  mmio_counter #(.WIDTH(32)) u_br_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (br_retire),
    .count (br_cnt)
  );

  mmio_counter #(.WIDTH(32)) u_br_ok_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (br_retire && br_correct),
    .count (br_ok_cnt)
  );

  assign unused_bits = ^{req_addr[31:8], req_wdata[31:8]};
`else
  assign br_cnt      = '0;
  assign br_ok_cnt   = '0;
  assign unused_bits = ^{req_addr[31:8], req_wdata[31:8], br_retire, br_correct};
`endif

  // Counters are read before this edge's increment; write-only and unmapped offsets read 0.
  always_comb begin
    rdata_nxt = '0;
    case (off)
      UART_CTRL: rdata_nxt = {30'b0, rx_valid, !tx_full};
      UART_RX:   rdata_nxt = rx_valid ? {24'b0, rx_data} : 32'h0;
      CYC_CNT:   rdata_nxt = cyc_cnt;
      INSTR_CNT: rdata_nxt = instr_cnt;
      BR_CNT:    rdata_nxt = br_cnt;
      BR_OK_CNT: rdata_nxt = br_ok_cnt;
      default:   rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (is_ld) begin
      rdata <= rdata_nxt;
    end
  end

endmodule
